stopwatch_ctrl: RTL and testbench

Control FSM that sequences the stopwatch counter from two user pulses: start/stop and lap/reset. It contains a tick prescaler and drives the counter's reset/start/stop inputs so that the counter advances exactly once per tick while running. It holds a lap snapshot for display and emits a carry pulse on wrap, so a second counter stage (e.g. minutes) can be cascaded. It sits between the debounced button logic and the counter/display path.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_tick_prescaler.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control slice.
//   state_t            : control FSM state, 2-bit encoding
//   DEFAULT_DATA_WIDTH : default width of the counter value / display bus
//   DEFAULT_MAX        : default terminal count of the driven counter
//   is_counting()      : true in the states where the prescaler runs
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_MAX        = 99;

    function automatic logic is_counting(input state_t s);
        return (s == RUNNING) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Tick prescaler: divides clk by TICK_DIV while enabled.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset, clears the phase counter
//   en      : advance the phase counter this cycle (wraps to 0 after TICK_DIV-1)
//   clr     : force the phase counter to 0 (lower priority than reset)
//   tick    : phase counter is at TICK_DIV-1 (raw terminal flag, not gated by en)
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_tick_cnt;

    assign tick = (r_tick_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (clr) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            r_tick_cnt <= tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM. Turns start/stop and lap/reset pulses into the
// counter's reset/start/stop controls, one counter advance per prescaler tick.
//   clk, reset_n : clock, synchronous active-low reset
//   btn_ss       : start/stop pulse (wins over btn_lr in the same cycle)
//   btn_lr       : lap/reset pulse
//   count_in     : current value of the driven counter
//   cnt_reset    : registered counter clear, one-cycle pulse on a reset request
//   cnt_start    : registered, high for one cycle after each tick edge
//   cnt_stop     : registered, low only in the cycle cnt_start is high
//   carry        : registered one-cycle pulse when the tick wraps MAX->0
//   display      : lap snapshot while in LAP, otherwise the live count
//   running      : high in RUNNING or LAP
//   lap_frozen   : high in LAP
//   dbg_state    : current FSM state, for observation only
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX        = DEFAULT_MAX,
    parameter int TICK_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btn_ss,
    input  logic                  btn_lr,
    input  logic [DATA_WIDTH-1:0] count_in,
    output logic                  cnt_reset,
    output logic                  cnt_start,
    output logic                  cnt_stop,
    output logic                  carry,
    output logic [DATA_WIDTH-1:0] display,
    output logic                  running,
    output logic                  lap_frozen,
    output logic [1:0]            dbg_state
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_cnt_reset;
    logic                  r_cnt_start;
    logic                  r_cnt_stop;
    logic                  r_carry;

    state_t                w_state_next;
    logic                  w_clear_req;
    logic                  w_lap_capture;
    logic                  w_counting;
    logic                  w_at_term;
    logic                  w_tick;
    logic                  w_pre_en;
    logic                  w_pre_clr;

    assign w_counting = is_counting(r_state);

    // A start/stop press on the terminal phase swallows the tick and freezes
    // the phase, so resuming later finishes that tick instead of leaking an
    // increment into the paused period.
    assign w_tick    = w_counting && w_at_term && !btn_ss;
    assign w_pre_en  = w_counting && !(btn_ss && w_at_term);
    assign w_pre_clr = (r_state == IDLE) ||
                       ((r_state == PAUSED) && btn_lr && !btn_ss);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_pre_en),
        .clr     (w_pre_clr),
        .tick    (w_at_term)
    );

    always_comb begin
        w_state_next  = r_state;
        w_clear_req   = 1'b0;
        w_lap_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (btn_ss)      w_state_next = RUNNING;
                else if (btn_lr) w_clear_req  = 1'b1;
            end
            RUNNING: begin
                if (btn_ss) begin
                    w_state_next = PAUSED;
                end else if (btn_lr) begin
                    w_state_next  = LAP;
                    w_lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (btn_ss)      w_state_next = PAUSED;
                else if (btn_lr) w_state_next = RUNNING;
            end
            PAUSED: begin
                if (btn_ss) begin
                    w_state_next = RUNNING;
                end else if (btn_lr) begin
                    w_state_next = IDLE;
                    w_clear_req  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_cnt_reset <= 1'b1;
            r_cnt_start <= 1'b0;
            r_cnt_stop  <= 1'b1;
            r_carry     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            if (w_lap_capture) r_hold <= count_in;
            r_cnt_reset <= w_clear_req;
            r_cnt_start <= w_tick;
            r_cnt_stop  <= !w_tick;
            // count_in is still the pre-increment value here; the counter
            // wraps on the next edge, in step with this pulse.
            r_carry     <= w_tick && (count_in == DATA_WIDTH'(MAX));
        end
    end

    assign cnt_reset  = r_cnt_reset;
    assign cnt_start  = r_cnt_start;
    assign cnt_stop   = r_cnt_stop;
    assign carry      = r_carry;
    assign display    = (r_state == LAP) ? r_hold : count_in;
    assign running    = w_counting;
    assign lap_frozen = (r_state == LAP);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int DW   = 16;
  localparam int MAXV = 9;
  localparam int TDIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_ss = 1'b0;
  logic btn_lr = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] count_in;
  logic          cnt_reset, cnt_start, cnt_stop, carry, running, lap_frozen;
  logic [DW-1:0] display;
  logic [1:0]    dbg_state;

  stopwatch_ctrl #(
    .DATA_WIDTH (DW),
    .MAX        (MAXV),
    .TICK_DIV   (TDIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .count_in   (count_in),
    .cnt_reset  (cnt_reset),
    .cnt_start  (cnt_start),
    .cnt_stop   (cnt_stop),
    .carry      (carry),
    .display    (display),
    .running    (running),
    .lap_frozen (lap_frozen),
    .dbg_state  (dbg_state)
  );

  // the counter being driven: clear, or advance once when started, wrap at MAXV
  initial count_in = '0;
  always @(posedge clk) begin
    if (cnt_reset === 1'b1) count_in <= '0;
    else if (cnt_start === 1'b1 && cnt_stop === 1'b0)
      count_in <= (count_in == DW'(MAXV)) ? '0 : count_in + 16'd1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode flags: idle = neither active nor paused; active covers running and lap.
  bit m_valid = 0;
  bit m_active = 0, m_paused = 0, m_lap = 0;
  int m_phase = 0, m_hold = 0, m_count = 0;
  bit e_reset = 1, e_start = 0, e_stop = 1, e_carry = 0;
  bit m_tick;

  assign m_tick = m_active && (m_phase == TDIV - 1) && !btn_ss;

  always @(posedge clk) begin
    // counter reacts to the controls that were registered on the previous edge
    if (e_reset) m_count <= 0;
    else if (e_start && !e_stop) m_count <= (m_count == MAXV) ? 0 : m_count + 1;

    if (!reset_n) begin
      m_valid <= 1; m_active <= 0; m_paused <= 0; m_lap <= 0;
      m_phase <= 0; m_hold <= 0;
      e_reset <= 1; e_start <= 0; e_stop <= 1; e_carry <= 0;
    end else begin
      e_reset <= btn_lr && !btn_ss && !m_active;
      e_start <= m_tick;
      e_stop  <= !m_tick;
      e_carry <= m_tick && (m_count == MAXV);

      if (!m_active && !m_paused) m_phase <= 0;
      else if (m_paused && btn_lr && !btn_ss) m_phase <= 0;
      else if (m_active && !(btn_ss && m_phase == TDIV - 1)) m_phase <= (m_phase + 1) % TDIV;

      if (btn_ss) begin
        m_lap <= 0;
        if (m_active) begin m_active <= 0; m_paused <= 1; end
        else begin m_active <= 1; m_paused <= 0; end
      end else if (btn_lr) begin
        if (m_active) begin
          m_lap <= !m_lap;
          if (!m_lap) m_hold <= m_count;
        end else if (m_paused) begin
          m_paused <= 0;
        end
      end
    end
  end

  // every-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cnt_reset", 32'(cnt_reset), 32'(e_reset));
      chk("cnt_start", 32'(cnt_start), 32'(e_start));
      chk("cnt_stop", 32'(cnt_stop), 32'(e_stop));
      chk("carry", 32'(carry), 32'(e_carry));
      chk("count_in", 32'(count_in), 32'(m_count));
      chk("display", 32'(display), 32'(m_lap ? m_hold : m_count));
      chk("running", 32'(running), 32'(m_active));
      chk("lap_frozen", 32'(lap_frozen), 32'(m_lap));
      chk("state", 32'(dbg_state), m_lap ? 32'd3 : m_active ? 32'd1 : m_paused ? 32'd2 : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // returns 2 time units after edge k has been taken
  task automatic to_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // the buttons are sampled by edge k
  task automatic press(input bit ss, input bit lr, input int k);
    to_edge(k - 1);
    btn_ss = ss;
    btn_lr = lr;
    to_edge(k);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);

    to_edge(3);
    chk("rst cnt_reset", 32'(cnt_reset), 1);
    chk("rst cnt_start", 32'(cnt_start), 0);
    chk("rst cnt_stop", 32'(cnt_stop), 1);
    chk("rst carry", 32'(carry), 0);
    chk("rst state", 32'(dbg_state), 0);
    chk("rst display", 32'(display), 0);
    reset_n = 1'b1;

    // 1: start at edge 10, first tick at 14, increments at 15, 19, 23
    press(1, 0, 10);
    chk("t1 running", 32'(running), 1);
    to_edge(13); chk("t1 start early", 32'(cnt_start), 0);
    to_edge(14); chk("t1 start", 32'(cnt_start), 1);
    chk("t1 count pre", 32'(count_in), 0);
    to_edge(15); chk("t1 count@15", 32'(count_in), 32'(exp_q.pop_front()));
    to_edge(19); chk("t1 count@19", 32'(count_in), 32'(exp_q.pop_front()));
    to_edge(23); chk("t1 count@23", 32'(count_in), 32'(exp_q.pop_front()));

    // 2: wrap 9 -> 0 with a one-cycle carry on the tick edge 50
    to_edge(47); chk("t2 count 9", 32'(count_in), 9);
    to_edge(49); chk("t2 carry pre", 32'(carry), 0);
    to_edge(50); chk("t2 carry", 32'(carry), 1);
    chk("t2 start", 32'(cnt_start), 1);
    to_edge(51); chk("t2 carry post", 32'(carry), 0);
    chk("t2 wrap", 32'(count_in), 0);
    chk("t2 running", 32'(running), 1);

    // 3: lap at count 3, counting continues underneath, release at 72
    to_edge(63); chk("t3 count 3", 32'(count_in), 3);
    press(0, 1, 64);
    to_edge(71); chk("t3 count 5", 32'(count_in), 5);
    chk("t3 display held", 32'(display), 3);
    chk("t3 lap_frozen", 32'(lap_frozen), 1);
    press(0, 1, 72);
    chk("t3 display live", 32'(display), 5);
    chk("t3 lap released", 32'(lap_frozen), 0);

    // 4: pause on the tick edge 74, resume at 76, tick follows at 77
    press(1, 0, 74);
    chk("t4 paused", 32'(dbg_state), 2);
    chk("t4 no start", 32'(cnt_start), 0);
    to_edge(75); chk("t4 no increment", 32'(count_in), 5);
    press(1, 0, 76);
    chk("t4 resumed", 32'(dbg_state), 1);
    chk("t4 start not yet", 32'(cnt_start), 0);
    to_edge(77); chk("t4 start", 32'(cnt_start), 1);
    to_edge(78); chk("t4 count 6", 32'(count_in), 6);

    // 5: pause at count 6 on tick edge 81, clear from pause, then ss+lr in idle
    press(1, 0, 81);
    to_edge(82); chk("t5 held 6", 32'(count_in), 6);
    press(0, 1, 83);
    chk("t5 cnt_reset", 32'(cnt_reset), 1);
    chk("t5 idle", 32'(dbg_state), 0);
    chk("t5 running", 32'(running), 0);
    to_edge(84); chk("t5 cnt_reset once", 32'(cnt_reset), 0);
    chk("t5 cleared", 32'(count_in), 0);
    press(1, 1, 86);
    chk("t5 ss wins", 32'(dbg_state), 1);
    chk("t5 no cnt_reset", 32'(cnt_reset), 0);

    // 6: reset while in LAP at count 7, on what would be a tick edge (118)
    to_edge(115); chk("t6 count 7", 32'(count_in), 7);
    press(0, 1, 116);
    chk("t6 lap", 32'(lap_frozen), 1);
    to_edge(117);
    reset_n = 1'b0;
    to_edge(118);
    reset_n = 1'b1;
    chk("t6 state", 32'(dbg_state), 0);
    chk("t6 cnt_reset", 32'(cnt_reset), 1);
    chk("t6 cnt_stop", 32'(cnt_stop), 1);
    chk("t6 cnt_start", 32'(cnt_start), 0);
    chk("t6 carry", 32'(carry), 0);
    chk("t6 lap", 32'(lap_frozen), 0);
    // the display follows count_in once the counter has cleared
    to_edge(119); chk("t6 count 0", 32'(count_in), 0);
    chk("t6 display", 32'(display), 0);
    chk("t6 cnt_reset off", 32'(cnt_reset), 0);

    to_edge(124);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
